// File: rtl/shift_button_conditioner.sv
// shift_button_conditioner
//   Turns two raw, bouncy push buttons into clean one-cycle shift commands
//   for the LED shifter. Each button runs through its own lane:
//   2-flop synchronizer -> counter debouncer -> rising-edge one-shot ->
//   optional hold-to-repeat. A chord rule then drops any event whose
//   opposite button is currently held, so both shifts never fire together.
//
// Ports
//   clk          system clock, all state on rising edge
//   reset        async active-low reset
//   btn_left     raw left button, active-high
//   btn_right    raw right button, active-high
//   shift_left   registered one-cycle left-shift command
//   shift_right  registered one-cycle right-shift command
//   pressed      registered debounced levels {left, right}

// One button lane: synchronize, debounce, detect press, generate repeats.
module shift_button_lane #(
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic db,
  output logic ev
);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2, db_q;
  logic [CNT_W-1:0] cnt;
  logic             press, rep_ev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db   <= 1'b0;
      db_q <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      db_q <= db;
      // Any cycle where s2 agrees with db restarts the run.
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Rising edge of the debounced level only; release never generates events.
  assign press = db & ~db_q;

  generate
    if (REPEAT_CYCLES == 0) begin : g_norep
      assign rep_ev = 1'b0;
    end else begin : g_rep
      localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
      logic [CNT_W-1:0] rep;

      // Keeps counting while the event is chord-suppressed, so a held button
      // resumes on its original schedule once the other is released.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rep <= '0;
        end else if (!db || press || rep == REP_LAST) begin
          rep <= '0;
        end else begin
          rep <= rep + CNT_W'(1);
        end
      end

      assign rep_ev = db & ~press & (rep == REP_LAST);
    end
  endgenerate

  assign ev = press | rep_ev;
endmodule

module shift_button_conditioner #(
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       shift_left,
  output logic       shift_right,
  output logic [1:0] pressed
);
  localparam int NUM_LANES = 2;   // lane 1 = left, lane 0 = right

  logic [NUM_LANES-1:0] btn_vec, db_vec, ev_vec;

  assign btn_vec = {btn_left, btn_right};

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      shift_button_lane #(
        .CNT_W          (CNT_W),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
      ) u_lane (
        .clk  (clk),
        .reset(reset),
        .btn  (btn_vec[i]),
        .db   (db_vec[i]),
        .ev   (ev_vec[i])
      );
    end
  endgenerate

  // db is already a flop, so pressed is registered.
  assign pressed = db_vec;

  // Chord rule: an event survives only if the other button is not held.
  // Simultaneous presses see each other's db high and both drop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_left  <= 1'b0;
      shift_right <= 1'b0;
    end else begin
      shift_left  <= ev_vec[1] & ~db_vec[0];
      shift_right <= ev_vec[0] & ~db_vec[1];
    end
  end
endmodule

// File: tb/tb_shift_button_conditioner.sv
module tb_shift_button_conditioner;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_left = 1'b0, btn_right = 1'b0;
  logic       sl0, sr0, sl1, sr1;
  logic [1:0] pr0, pr1;

  always #5 clk = ~clk;

  // dut0: defaults (no repeat); dut1: REPEAT_CYCLES = 8. Shared stimulus.
  shift_button_conditioner dut0 (
    .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right),
    .shift_left(sl0), .shift_right(sr0), .pressed(pr0));

  shift_button_conditioner #(.REPEAT_CYCLES(8)) dut1 (
    .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right),
    .shift_left(sl1), .shift_right(sr1), .pressed(pr1));

  int cyc = 0;   // index of the most recent rising edge
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  bit sb_en = 1'b1;

  // Scoreboard queues of required pulse edges: 0=dut0 L, 1=dut0 R, 2=dut1 L, 3=dut1 R
  int exp_q [4][$];

  logic [3:0] sh, sh_q = 4'b0;
  assign sh = {sr1, sl1, sr0, sl0};

  int         mon_e;
  logic [1:0] mon_pr;
  logic [1:0] pr_q [2];
  int         last_chg [2][2];

  // Monitor: pops the scoreboard when a pulse appears, and checks exclusivity,
  // pulse width and pressed stability every cycle.
  always @(negedge clk) begin
    if (sb_en) begin
      for (int k = 0; k < 4; k++) begin
        if (sh[k]) begin
          n_cmp++;
          if (exp_q[k].size() == 0) begin
            n_err++;
            $display("FAIL pulse_sched ch%0d: pulse at edge %0d, none required", k, cyc);
          end else begin
            mon_e = exp_q[k].pop_front();
            if (mon_e != cyc) begin
              n_err++;
              $display("FAIL pulse_sched ch%0d: pulse at edge %0d, required at edge %0d", k, cyc, mon_e);
            end
          end
        end
      end
    end
    n_cmp++;
    if ((sl0 & sr0) !== 1'b0 || (sl1 & sr1) !== 1'b0) begin
      n_err++;
      $display("FAIL exclusive: edge %0d shifts=%b, required no L&R", cyc, sh);
    end
    for (int k = 0; k < 4; k++) begin
      if (sh[k]) begin
        n_cmp++;
        if (sh_q[k]) begin
          n_err++;
          $display("FAIL pulse_width ch%0d: high 2 cycles at edge %0d, required 1", k, cyc);
        end
      end
    end
    sh_q = sh;
    for (int d = 0; d < 2; d++) begin
      mon_pr = (d == 0) ? pr0 : pr1;
      for (int b = 0; b < 2; b++) begin
        if (!reset) begin
          pr_q[d][b]     = 1'b0;
          last_chg[d][b] = -100;
        end else if (mon_pr[b] !== pr_q[d][b]) begin
          n_cmp++;
          if (cyc - last_chg[d][b] < 4) begin
            n_err++;
            $display("FAIL pressed_stable dut%0d bit%0d: changed after %0d cycles, required >= 4",
                     d, b, cyc - last_chg[d][b]);
          end
          last_chg[d][b] = cyc;
          pr_q[d][b]     = mon_pr[b];
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    #1 reset = 1'b0;
    step(2);
    n_cmp++;
    if ({sl0, sr0, pr0} !== 4'b0) begin
      n_err++; $display("FAIL reset_dut0: outputs=%b, required 0000", {sl0, sr0, pr0});
    end
    n_cmp++;
    if ({sl1, sr1, pr1} !== 4'b0) begin
      n_err++; $display("FAIL reset_dut1: outputs=%b, required 0000", {sl1, sr1, pr1});
    end
    reset = 1'b1;
    step(3);
    n_cmp++;
    if ({sl0, sr0, pr0, sl1, sr1, pr1} !== 8'b0) begin
      n_err++; $display("FAIL reset_idle: outputs=%b, required 0", {sl0, sr0, pr0, sl1, sr1, pr1});
    end
  endtask

  task automatic test_clean_press;
    int e0;
    e0 = cyc + 1;
    btn_left = 1'b1;
    exp_q[0].push_back(e0 + 6);
    exp_q[2].push_back(e0 + 6); exp_q[2].push_back(e0 + 14); exp_q[2].push_back(e0 + 22);
    step(5);   // after e4
    n_cmp++;
    if (pr0 !== 2'b00) begin
      n_err++; $display("FAIL clean_pressed_e4: pressed=%b, required 00", pr0);
    end
    step(1);   // after e5
    n_cmp++;
    if (pr0 !== 2'b10 || pr1 !== 2'b10) begin
      n_err++; $display("FAIL clean_pressed_e5: pressed=%b/%b, required 10/10", pr0, pr1);
    end
    step(14);  // after e19
    btn_left = 1'b0;
    step(20);
    n_cmp++;
    if (pr0 !== 2'b00) begin
      n_err++; $display("FAIL clean_released: pressed=%b, required 00", pr0);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (exp_q[k].size() != 0) begin
        n_err++; $display("FAIL clean_missing ch%0d: %0d pulses outstanding, required 0", k, exp_q[k].size());
        exp_q[k].delete();
      end
    end
  endtask

  task automatic test_bounce;
    int e0;
    bit seq [10];
    seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    e0 = cyc + 1;
    exp_q[1].push_back(e0 + 11);
    exp_q[3].push_back(e0 + 11);
    for (int i = 0; i < 10; i++) begin
      btn_right = seq[i];
      step(1);
    end
    n_cmp++;   // after e9: last run not yet 4 long
    if (pr0 !== 2'b00) begin
      n_err++; $display("FAIL bounce_early: pressed=%b, required 00", pr0);
    end
    step(1);   // after e10
    n_cmp++;
    if (pr0 !== 2'b01) begin
      n_err++; $display("FAIL bounce_settled: pressed=%b, required 01", pr0);
    end
    step(1);
    btn_right = 1'b0;
    step(20);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (exp_q[k].size() != 0) begin
        n_err++; $display("FAIL bounce_missing ch%0d: %0d pulses outstanding, required 0", k, exp_q[k].size());
        exp_q[k].delete();
      end
    end
  endtask

  task automatic test_repeat;
    int e0;
    e0 = cyc + 1;
    btn_left = 1'b1;
    exp_q[0].push_back(e0 + 6);
    for (int p = 6; p <= 38; p += 8) exp_q[2].push_back(e0 + p);
    step(40);
    btn_left = 1'b0;
    step(20);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (exp_q[k].size() != 0) begin
        n_err++; $display("FAIL repeat_missing ch%0d: %0d pulses outstanding, required 0", k, exp_q[k].size());
        exp_q[k].delete();
      end
    end
  endtask

  task automatic test_chord;
    int e0;
    e0 = cyc + 1;
    btn_left = 1'b1;
    exp_q[0].push_back(e0 + 6);
    exp_q[2].push_back(e0 + 6); exp_q[2].push_back(e0 + 14); exp_q[2].push_back(e0 + 38);
    step(10);
    btn_right = 1'b1;
    step(10);
    n_cmp++;
    if (pr0 !== 2'b11 || pr1 !== 2'b11) begin
      n_err++; $display("FAIL chord_pressed: pressed=%b/%b, required 11/11", pr0, pr1);
    end
    step(10);
    btn_right = 1'b0;
    step(10);
    btn_left = 1'b0;
    step(20);
    // Both pressed in the same cycle: no pulse at all on either DUT.
    btn_left  = 1'b1;
    btn_right = 1'b1;
    step(6);
    n_cmp++;
    if (pr0 !== 2'b11) begin
      n_err++; $display("FAIL chord_both_pressed: pressed=%b, required 11", pr0);
    end
    step(24);
    btn_left  = 1'b0;
    btn_right = 1'b0;
    step(20);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (exp_q[k].size() != 0) begin
        n_err++; $display("FAIL chord_missing ch%0d: %0d pulses outstanding, required 0", k, exp_q[k].size());
        exp_q[k].delete();
      end
    end
  endtask

  task automatic test_reset_mid_pulse;
    int e0;
    e0 = cyc + 1;
    btn_left = 1'b1;
    exp_q[0].push_back(e0 + 6);
    exp_q[2].push_back(e0 + 6);
    step(7);   // after e6, pulse high
    n_cmp++;
    if (sl0 !== 1'b1 || sl1 !== 1'b1) begin
      n_err++; $display("FAIL pulse_before_reset: shift_left=%b/%b, required 1/1", sl0, sl1);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({sl0, sr0, pr0, sl1, sr1, pr1} !== 8'b0) begin
      n_err++; $display("FAIL reset_truncate: outputs=%b, required 0", {sl0, sr0, pr0, sl1, sr1, pr1});
    end
    btn_left = 1'b0;
    step(2);
    reset = 1'b1;
    step(15);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (exp_q[k].size() != 0) begin
        n_err++; $display("FAIL midpulse_missing ch%0d: %0d pulses outstanding, required 0", k, exp_q[k].size());
        exp_q[k].delete();
      end
    end
  endtask

  task automatic test_reset_mid_hold;
    int e0;
    btn_left = 1'b1;
    step(4);   // after e3, original pulse due at e6
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({sl0, sr0, pr0, sl1, sr1, pr1} !== 8'b0) begin
      n_err++; $display("FAIL reset_hold_async: outputs=%b, required 0", {sl0, sr0, pr0, sl1, sr1, pr1});
    end
    step(2);
    reset = 1'b1;
    e0 = cyc + 1;
    exp_q[0].push_back(e0 + 6);
    exp_q[2].push_back(e0 + 6); exp_q[2].push_back(e0 + 14);
    step(10);
    btn_left = 1'b0;
    step(20);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (exp_q[k].size() != 0) begin
        n_err++; $display("FAIL midhold_missing ch%0d: %0d pulses outstanding, required 0", k, exp_q[k].size());
        exp_q[k].delete();
      end
    end
  endtask

  task automatic test_random;
    sb_en = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 5) == 0) btn_left  = ~btn_left;
      if ($urandom_range(0, 5) == 0) btn_right = ~btn_right;
      step(1);
    end
    btn_left  = 1'b0;
    btn_right = 1'b0;
    step(20);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_chord();
    test_reset_mid_pulse();
    test_reset_mid_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
